// File: rtl/pos_read_controller.sv
// pos_read_controller: sequences home x neighbour particle reads for pos_data_preprocessor.
// Optional saturating back-pressure stall counter enabled by POS_READ_STALL_CNT_EN.
module pos_read_controller #(
    parameter int NUM_NEIGHBOR_CELLS = 13,
    parameter int PARTICLE_ID_WIDTH  = 7
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic                                                back_pressure,
    input  logic [(NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH-1:0] cell_particle_num,
    output logic [PARTICLE_ID_WIDTH-1:0]                        rd_addr,
    output logic                                                phase,
    output logic                                                pause_reading,
    output logic                                                reading_particle_num,
    output logic [PARTICLE_ID_WIDTH-1:0]                        particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0]                        ref_id,
    output logic [NUM_NEIGHBOR_CELLS:0]                         broadcast_done,
`ifdef POS_READ_STALL_CNT_EN
    output logic [15:0]                                         stall_cycles,
`endif
    output logic                                                busy,
    output logic                                                done
);
    localparam int N = NUM_NEIGHBOR_CELLS + 1;
    localparam int W = PARTICLE_ID_WIDTH;

    typedef enum logic [2:0] {IDLE, RD_NUM, LATCH, SWEEP, DONE} state_t;

    state_t         state, state_n;
    logic [W-1:0]   cnt [N];
    logic [W-1:0]   cnt_in [N];
    logic [W-1:0]   max_cnt, max_in;
    logic           wrap, last;
    logic [W-1:0]   rd_addr_d, particle_id_d, ref_id_d;
    logic           phase_d, pause_d, rpn_d;
    logic [N-1:0]   bd_d;

    // unpack the count word and find the largest cell
    always_comb begin
        max_in = '0;
        for (int c = 0; c < N; c++) begin
            cnt_in[c] = cell_particle_num[c*W +: W];
            max_in    = cnt_in[c] > max_in ? cnt_in[c] : max_in;
        end
    end

    assign wrap = particle_id == max_cnt;
    assign last = phase && wrap && ref_id == cnt[0];

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RD_NUM : IDLE;
            RD_NUM:  state_n = LATCH;
            LATCH:   state_n = cnt_in[0] == '0 ? DONE : SWEEP;
            SWEEP:   state_n = (!back_pressure && last) ? DONE : SWEEP;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        rd_addr_d     = rd_addr;
        particle_id_d = particle_id;
        ref_id_d      = ref_id;
        phase_d       = phase;
        bd_d          = broadcast_done;
        rpn_d         = state_n == RD_NUM;
        pause_d       = state == SWEEP && back_pressure;
        if (state == IDLE && start)
            rd_addr_d = '0;
        if (state == LATCH && state_n == SWEEP) begin
            ref_id_d      = W'(1);
            particle_id_d = W'(1);
            rd_addr_d     = W'(1);
            phase_d       = 1'b0;
            for (int c = 0; c < N; c++)
                bd_d[c] = cnt_in[c] == '0;
        end
        if (state == SWEEP && !back_pressure && !last) begin
            particle_id_d = wrap ? W'(1) : particle_id + 1'b1;
            phase_d       = wrap ? ~phase : phase;
            ref_id_d      = (wrap && phase && ref_id < cnt[0]) ? ref_id + 1'b1 : ref_id;
            rd_addr_d     = particle_id_d;
            for (int c = 0; c < N; c++)
                bd_d[c] = particle_id_d > cnt[c];
        end
        if (state_n == DONE)
            bd_d = '1;
    end

    // output and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr              <= '0;
            phase                <= 1'b0;
            pause_reading        <= 1'b0;
            reading_particle_num <= 1'b0;
            particle_id          <= '0;
            ref_id               <= '0;
            broadcast_done       <= '1;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            max_cnt              <= '0;
            for (int c = 0; c < N; c++)
                cnt[c] <= '0;
        end else begin
            if (state == LATCH) begin
                cnt     <= cnt_in;
                max_cnt <= max_in;
            end
            rd_addr              <= rd_addr_d;
            phase                <= phase_d;
            pause_reading        <= pause_d;
            reading_particle_num <= rpn_d;
            particle_id          <= particle_id_d;
            ref_id               <= ref_id_d;
            broadcast_done       <= bd_d;
            busy                 <= state_n != IDLE;
            done                 <= state_n == DONE;
        end
    end

`ifdef POS_READ_STALL_CNT_EN
    // count back-pressured sweep cycles, saturating, cleared on each new evaluation
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start))
            stall_cycles <= '0;
        else if (state == SWEEP && back_pressure && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pos_read_controller.sv
// tb_pos_read_controller: directed and randomized checks of pos_read_controller against a nested-loop sweep model.
module tb_pos_read_controller;
    localparam int NC = 13;
    localparam int W  = 7;
    localparam int N  = NC + 1;

    logic           clk = 1'b0;
    logic           rst, start, back_pressure;
    logic [N*W-1:0] cell_particle_num;
    logic [W-1:0]   rd_addr, particle_id, ref_id;
    logic           phase, pause_reading, reading_particle_num, busy, done;
    logic [N-1:0]   broadcast_done;
`ifdef POS_READ_STALL_CNT_EN
    logic [15:0]    stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int cnts [N];

    pos_read_controller #(.NUM_NEIGHBOR_CELLS(NC), .PARTICLE_ID_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .back_pressure(back_pressure),
        .cell_particle_num(cell_particle_num),
        .rd_addr(rd_addr),
        .phase(phase),
        .pause_reading(pause_reading),
        .reading_particle_num(reading_particle_num),
        .particle_id(particle_id),
        .ref_id(ref_id),
        .broadcast_done(broadcast_done),
`ifdef POS_READ_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        cell_particle_num = t[N*W-1:0];
    endtask

    task automatic pack_counts();
        for (int c = 0; c < N; c++)
            cell_particle_num[c*W +: W] = 7'(cnts[c]);
    endtask

    task automatic check_reset();
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_pause", 32'(pause_reading), 0);
        chk("rst_rpn", 32'(reading_particle_num), 0);
        chk("rst_pid", 32'(particle_id), 0);
        chk("rst_ref", 32'(ref_id), 0);
        chk("rst_bd", 32'(broadcast_done), 32'h3FFF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef POS_READ_STALL_CNT_EN
        chk("rst_stall", 32'(stall_cycles), 0);
`endif
    endtask

    // one evaluation from IDLE; the model is the nested ref/phase/particle loop
    task automatic run(input int stall_idx, input int stall_len, input bit rnd,
                       input int abort_at, input bit hold_start);
        int q_r[$], q_ph[$], q_p[$];
        int mx, idx, stalls, left;
        bit rep;
        logic [N-1:0] exp_bd;
        mx = 0;
        foreach (cnts[c]) if (cnts[c] > mx) mx = cnts[c];
        for (int r = 1; r <= cnts[0]; r++)
            for (int ph = 0; ph < 2; ph++)
                for (int p = 1; p <= mx; p++) begin
                    q_r.push_back(r);
                    q_ph.push_back(ph);
                    q_p.push_back(p);
                end
        start = 1'b1;
        scramble();
        @(negedge clk);
        chk("rdnum_rpn", 32'(reading_particle_num), 1);
        chk("rdnum_addr", 32'(rd_addr), 0);
        chk("rdnum_busy", 32'(busy), 1);
        if (!hold_start) start = 1'b0;
        @(negedge clk);
        chk("latch_rpn", 32'(reading_particle_num), 0);
        chk("latch_busy", 32'(busy), 1);
        chk("latch_addr", 32'(rd_addr), 0);
        pack_counts();
        idx = 0;
        rep = 1'b0;
        stalls = 0;
        left = stall_len;
        while (idx < q_p.size()) begin
            @(negedge clk);
            scramble();
            for (int c = 0; c < N; c++)
                exp_bd[c] = q_p[idx] > cnts[c];
            chk("sw_pid", 32'(particle_id), q_p[idx]);
            chk("sw_ref", 32'(ref_id), q_r[idx]);
            chk("sw_phase", 32'(phase), q_ph[idx]);
            chk("sw_addr", 32'(rd_addr), q_p[idx]);
            chk("sw_pause", 32'(pause_reading), 32'(rep));
            chk("sw_bd", 32'(broadcast_done), 32'(exp_bd));
            chk("sw_busy", 32'(busy), 1);
            chk("sw_done", 32'(done), 0);
            if (idx == abort_at && !rep) begin
                back_pressure = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                check_reset();
                return;
            end
            back_pressure = 1'b0;
            if (idx == stall_idx && left > 0) begin
                back_pressure = 1'b1;
                left--;
            end else if (rnd && $urandom_range(0, 3) == 0)
                back_pressure = 1'b1;
            rep = back_pressure;
            if (back_pressure) stalls++;
            else idx++;
        end
        back_pressure = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_pause", 32'(pause_reading), 0);
        chk("done_bd", 32'(broadcast_done), 32'h3FFF);
        if (cnts[0] == 0) chk("done_addr0", 32'(rd_addr), 0);
`ifdef POS_READ_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cycles), stalls);
`endif
        @(negedge clk);
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        if (hold_start) begin
            @(negedge clk);
            chk("restart_busy", 32'(busy), 1);
            chk("restart_rpn", 32'(reading_particle_num), 1);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        back_pressure = 1'b0;
        cell_particle_num = '0;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;

        foreach (cnts[c]) cnts[c] = 3;
        cnts[0] = 2;
        run(-1, 0, 1'b0, -1, 1'b0);

        foreach (cnts[c]) cnts[c] = 4;
        cnts[0] = 1;
        cnts[5] = 1;
        run(-1, 0, 1'b0, -1, 1'b0);

        foreach (cnts[c]) cnts[c] = $urandom_range(0, 5);
        cnts[0] = 0;
        run(-1, 0, 1'b0, -1, 1'b0);

        foreach (cnts[c]) cnts[c] = 3;
        cnts[0] = 2;
        run(4, 3, 1'b0, -1, 1'b0);

        foreach (cnts[c]) cnts[c] = 2;
        cnts[0] = 1;
        run(3, 2, 1'b0, -1, 1'b0);

        foreach (cnts[c]) cnts[c] = 3;
        cnts[0] = 2;
        run(-1, 0, 1'b0, 3, 1'b0);
        @(negedge clk);
        chk("abort_no_done", 32'(done), 0);
        chk("abort_idle", 32'(busy), 0);
        run(-1, 0, 1'b0, -1, 1'b0);

        foreach (cnts[c]) cnts[c] = 2;
        cnts[0] = 2;
        run(-1, 0, 1'b0, -1, 1'b1);

        for (int it = 0; it < 6; it++) begin
            foreach (cnts[c]) cnts[c] = $urandom_range(0, 5);
            cnts[0] = $urandom_range(0, 3);
            if (it == 2) begin
                cnts[0] = 1;
                cnts[$urandom_range(1, NC)] = 127;
            end
            run(-1, 0, 1'b1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
